conv_post_pool: RTL
===================

# conv_post_pool

Output stage directly downstream of the convolution accumulator. It consumes the accumulator's per-pixel `sum`/`conv_comp` stream, applies ReLU, requantises to `DATA_WIDTH`, and performs 2x2 stride-2 max pooling over a raster-ordered feature map. Pooled pixels are queued in a small FIFO for the write-back path. The block runs only during conv layers; FC results bypass it.

## Interface
Parameters:
- `FMAP_W`, 28: conv output width in pixels; even, ≥2.
- `FMAP_H`, 28: conv output height in rows; even, ≥2.
- `DATA_WIDTH`, `DATA_WIDTH` macro: width of pooled output, signed.
- `BIAS_WIDTH`, `BIAS_WIDTH` macro: width of the incoming signed sum.
- `FRAC_SHIFT`, 8: right-shift applied in requantisation.
- `FIFO_DEPTH`, 4: output FIFO entries; power of two.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, synchronous, active-low.
- `frame_start`, in, 1: pulse; clears row/column state for a new feature map.
- `sum_in`, in, `BIAS_WIDTH`: signed accumulated pixel.
- `sum_valid`, in, 1: pixel strobe (driven by `conv_comp`); no backpressure possible.
- `out_data`, out, `DATA_WIDTH`: pooled pixel at FIFO head.
- `out_valid`, out, 1: FIFO non-empty.
- `out_ready`, in, 1: consumer accepts head when high with `out_valid`.
- `frame_done`, out, 1: one-cycle pulse when the last pooled pixel of a frame is written into the FIFO.
- `overflow`, out, 1: sticky; set when a pooled pixel arrives while the FIFO is full.

## Operation
- Stage 1 (requant): on `sum_valid`, compute `r = (sum_in < 0) ? 0 : sum_in >>> FRAC_SHIFT`, then saturate to `2^(DATA_WIDTH-1)-1`. Register `q` and `q_valid`.
- Stage 2 (pool), on `q_valid`, using counters `col` (0..FMAP_W-1) and `row` (0..FMAP_H-1):
  - Even `col`: hold `q` in `hmax`.
  - Odd `col`: `p = max(hmax, q)`.
    - Even `row`: write `p` into line buffer slot `col>>1`, which holds `FMAP_W/2` entries.
    - Odd `row`: push `max(linebuf[col>>1], p)` into the FIFO.
  - Advance `col`. On wrap, advance `row`. On the final pixel (`row=FMAP_H-1`, `col=FMAP_W-1`), pulse `frame_done` with the FIFO push, then clear `row` and `col` to 0.
- The pool stage uses unsigned compares. All values are non-negative after ReLU.
- FIFO:
  - Push and pop in the same cycle when full: both occur, and the count is unchanged.
  - Push while full with no pop: data is dropped, `overflow` is set, and pointers are unchanged.
  - Pop while empty is ignored.
- `frame_start` clears `col`, `row` and `hmax`, and drops any in-flight `q_valid`. FIFO contents and `overflow` are retained.
- `frame_start` coincident with `sum_valid`: the clear applies first, and the new sample becomes pixel (0,0) of the new frame.
- `overflow` clears only on reset.

## Timing
- Reset (`rst`=0 at an edge):
  - `out_valid`=0, `frame_done`=0, `overflow`=0, `out_data`=0.
  - Counters, FIFO pointers and `q_valid` are cleared.
  - Line buffer contents are don't-care.
- Reset mid-frame aborts the frame. No partial output is produced.
- Latency: a `sum_valid` sampled at edge E that completes a pool window is pushed at edge E+2. `out_valid` and `out_data` are visible after edge E+2.
- Throughput: one input pixel per cycle, sustained. One pooled output per four inputs on average; bursts of `FMAP_W/2` outputs occur on odd rows.
- `out_data` is the FIFO head (combinational read of registered storage). It is stable while `out_valid`=1 and `out_ready`=0.

## Configuration
- `CONV_POST_ROUND_EN`:
  - Defined: requantisation rounds half-up, `r = (sum_in + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT` for non-negative `sum_in`. The addition is performed at `BIAS_WIDTH+1` bits so it cannot wrap.
  - Undefined: truncating shift only.
- All other behaviour is identical in both builds.

## Structure
- The shared package `cae_pkg` holds:
  - the requant saturation constant `2^(DATA_WIDTH-1)-1`;
  - the `relu_requant` function;
  - the FIFO pointer width derived from `FIFO_DEPTH`.
- Sub-module `pool_fifo`: a synchronous FIFO with parameterised depth and width, exposing `push`, `pop`, `full`, `empty`, head data and a drop-on-full indication.
- Requant, pool counters and the line buffer stay in the top module.

## Test plan
Bench settings: `FMAP_W`=4, `FMAP_H`=4, `DATA_WIDTH`=8, `FRAC_SHIFT`=4, `FIFO_DEPTH`=4, `out_ready`=1 unless stated.

1. Requant: single window with sums 160, -50, 5000, 24 at pixels (0,0), (0,1), (1,0), (1,1) → values 10, 0, 127 (saturated), 1 (truncate build) or 2 (`CONV_POST_ROUND_EN` build). Pooled output is 127, appearing 2 edges after the (1,1) strobe.
2. Full frame: 16 back-to-back pixels with values `16*k` (k = raster index 0..15) → outputs 5, 7, 13, 15 in order. `frame_done` pulses with the push of 15.
3. Backpressure: `out_ready`=0 for a whole frame → 4 entries held, `overflow` stays 0. A second frame then pushes a 5th result → `overflow`=1 and the first 4 entries drain unchanged.
4. Simultaneous: full FIFO with `out_ready`=1 on the same cycle as a push → count stays 4 and `overflow` stays 0.
5. `frame_start` mid-row (after 6 pixels), coincident with a new `sum_valid` → the new frame's first output uses only pixels received after the restart. No stale `hmax` or line-buffer value leaks into it.
6. Reset asserted mid-frame with FIFO entries present → `out_valid`=0 and `overflow`=0 after the edge. The next frame produces correct outputs.

Source files
------------

// File: rtl/cae_pkg.sv
// Shared constants and helpers for the conv post-processing stage.
// Macros: DATA_WIDTH and BIAS_WIDTH supply default widths when not set by the build.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef BIAS_WIDTH
`define BIAS_WIDTH 32
`endif

package cae_pkg;

  localparam int unsigned REQ_DATA_W  = `DATA_WIDTH;
  localparam int unsigned REQ_BIAS_W  = `BIAS_WIDTH;
  // Largest positive value representable in a signed REQ_DATA_W word
  localparam int unsigned REQ_SAT_MAX = (32'd1 << (REQ_DATA_W - 1)) - 32'd1;

  // Counter/pointer width for a range of n values, never below one bit
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // FIFO read/write pointer width for a given depth
  function automatic int unsigned fifo_ptr_w(input int unsigned depth);
    return cnt_w(depth);
  endfunction

  // ReLU, optional half-up rounding, arithmetic shift and saturation to data_w.
  // The sum is carried at 65 bits so the rounding add can never wrap.
  function automatic logic [63:0] relu_requant(
    input logic signed [63:0] s,
    input int unsigned        frac_shift,
    input int unsigned        data_w,
    input logic               round_en
  );
    logic signed [64:0] t;
    logic [63:0]        sat;
    sat = (64'd1 << (data_w - 1)) - 64'd1;
    if (s[63]) begin
      return 64'd0;
    end
    t = 65'(s);
    if (round_en && (frac_shift != 0)) begin
      t = t + (65'sd1 <<< (frac_shift - 1));
    end
    t = t >>> frac_shift;
    if (64'(t) > sat) begin
      return sat;
    end
    return 64'(t);
  endfunction

endpackage

// File: rtl/pool_fifo.sv
// Small synchronous FIFO holding pooled pixels for the write-back path.
// Push while full with no pop drops the data and raises drop_c for that cycle.
module pool_fifo
  import cae_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_c,
  output logic             full,
  output logic             empty,
  output logic             drop_c
);

  localparam int unsigned PW = fifo_ptr_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             pop_ok;
  logic             push_ok;

  // Status flags, accepted push/pop and head read
  always_comb begin
    empty   = (count == '0);
    full    = (count == (PW+1)'(DEPTH));
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
    drop_c  = push && full && !pop_ok;
    head_c  = empty ? '0 : mem[rd_ptr];
  end

  // Storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/conv_post_pool.sv
// ReLU + requantisation + 2x2/2 max pooling after the conv accumulator.
// Macro CONV_POST_ROUND_EN selects half-up rounding in requantisation
// (undefined: truncating shift).
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef BIAS_WIDTH
`define BIAS_WIDTH 32
`endif

module conv_post_pool
  import cae_pkg::*;
#(
  parameter int unsigned FMAP_W     = 28,
  parameter int unsigned FMAP_H     = 28,
  parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
  parameter int unsigned BIAS_WIDTH = `BIAS_WIDTH,
  parameter int unsigned FRAC_SHIFT = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_start,
  input  logic signed [BIAS_WIDTH-1:0] sum_in,
  input  logic                         sum_valid,
  output logic        [DATA_WIDTH-1:0] out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         frame_done,
  output logic                         overflow
);

`ifdef CONV_POST_ROUND_EN
  localparam logic ROUND_EN = 1'b1;
`else
  localparam logic ROUND_EN = 1'b0;
`endif

  localparam int unsigned HALF_W = FMAP_W / 2;
  localparam int unsigned CW     = cnt_w(FMAP_W);
  localparam int unsigned RW     = cnt_w(FMAP_H);
  localparam int unsigned LBW    = cnt_w(HALF_W);

  logic [DATA_WIDTH-1:0] q;
  logic                  q_valid;
  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [DATA_WIDTH-1:0] hmax;
  logic [DATA_WIDTH-1:0] linebuf [HALF_W];
  logic [DATA_WIDTH-1:0] pool_data;
  logic                  pool_valid;
  logic                  pool_last;

  logic [LBW-1:0]        lb_idx_c;
  logic [DATA_WIDTH-1:0] pmax_c;
  logic [DATA_WIDTH-1:0] win_c;
  logic                  col_last_c;
  logic                  row_last_c;
  logic                  pool_step_c;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  fifo_drop_c;

  // Window arithmetic for the pixel currently in stage 2
  always_comb begin
    lb_idx_c    = LBW'(col >> 1);
    pmax_c      = (q > hmax) ? q : hmax;
    win_c       = (linebuf[lb_idx_c] > pmax_c) ? linebuf[lb_idx_c] : pmax_c;
    col_last_c  = (col == CW'(FMAP_W - 1));
    row_last_c  = (row == RW'(FMAP_H - 1));
    pool_step_c = q_valid && !frame_start;
  end

  // Stage 1: requantise each incoming sum
  always_ff @(posedge clk) begin
    if (!rst) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else begin
      q_valid <= sum_valid;
      if (sum_valid) begin
        q <= DATA_WIDTH'(relu_requant(64'(sum_in), FRAC_SHIFT, DATA_WIDTH, ROUND_EN));
      end
    end
  end

  // Stage 2: raster counters, horizontal max and window completion
  always_ff @(posedge clk) begin
    if (!rst) begin
      col        <= '0;
      row        <= '0;
      hmax       <= '0;
      pool_data  <= '0;
      pool_valid <= 1'b0;
      pool_last  <= 1'b0;
    end else begin
      pool_valid <= 1'b0;
      pool_last  <= 1'b0;
      if (frame_start) begin
        col  <= '0;
        row  <= '0;
        hmax <= '0;
      end else if (q_valid) begin
        if (!col[0]) begin
          hmax <= q;
        end else if (row[0]) begin
          pool_valid <= 1'b1;
          pool_data  <= win_c;
          pool_last  <= row_last_c && col_last_c;
        end
        if (col_last_c) begin
          col <= '0;
          row <= row_last_c ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Line buffer holds the even-row horizontal maxima
  always_ff @(posedge clk) begin
    if (pool_step_c && col[0] && !row[0]) begin
      linebuf[lb_idx_c] <= pmax_c;
    end
  end

  // Frame completion pulse and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= pool_valid && pool_last;
      overflow   <= overflow || fifo_drop_c;
    end
  end

  pool_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pool_valid),
    .push_data (pool_data),
    .pop       (out_ready),
    .head_c    (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop_c    (fifo_drop_c)
  );

  // Head is valid whenever the FIFO holds data
  always_comb begin
    out_valid = !fifo_empty;
  end

endmodule
